// File: rtl/decode_stage.sv
// Pipelined RV32I decode stage sitting between fetch and execute.
// It accepts {instr, pc} on a valid/ready handshake, decodes the control
// signals, register indices and sign-extended immediate, and registers the
// bundle for execute. It also flags illegal instructions and ECALL/EBREAK.
// Ports:
//   clk, rst (sync, active-high), flush
//   in_valid/in_ready/in_instr/in_pc  : fetch side handshake and payload
//   out_valid/out_ready               : execute side handshake
//   out_*                             : registered decoded bundle
module decode_stage #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned SKID_EN       = 1,
  parameter int unsigned ENABLE_SYSTEM = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic            out_reg_write_enable,
  output logic [1:0]      out_result_src,
  output logic            out_is_branch,
  output logic            out_is_jump,
  output logic            out_mem_write_enable,
  output logic [2:0]      out_mem_funct3,
  output logic [5:0]      out_alu_op,
  output logic            out_alu_input_config,
  output logic [2:0]      out_imm_sel,
  output logic            out_illegal,
  output logic            out_ecall,
  output logic            out_ebreak
);

  localparam int unsigned REG_W = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_U = 3'd1;
  localparam logic [2:0] IMM_J = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_S = 3'd4;

  localparam logic [5:0] ALU_ADD = 6'b110000;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [XLEN-1:0]  imm;
    logic             reg_we;
    logic [1:0]       result_src;
    logic             is_branch;
    logic             is_jump;
    logic             mem_we;
    logic [2:0]       mem_funct3;
    logic [5:0]       alu_op;
    logic             alu_cfg;
    logic [2:0]       imm_sel;
    logic             illegal;
    logic             ecall;
    logic             ebreak;
  } bundle_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  logic [31:0] imm32;
  bundle_t    dec_c;

  bundle_t out_q, out_d, skid_q, skid_d;
  logic    out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic    in_ready_c, accept_c, fire_c;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // Combinational decode of the incoming word; fields are only set on legal encodings
  always_comb begin
    dec_c            = '0;
    legal            = 1'b0;
    dec_c.pc         = in_pc;
    dec_c.rd         = in_instr[11:7];
    dec_c.rs1        = in_instr[19:15];
    dec_c.rs2        = in_instr[24:20];
    dec_c.mem_funct3 = funct3;
    dec_c.imm_sel    = IMM_I;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          legal         = 1'b1;
          dec_c.reg_we  = 1'b1;
          dec_c.alu_op  = {2'b00, in_instr[30], funct3};
        end
      end
      OPC_OPIMM: begin
        // Shift-immediates reuse funct7 as an encoding field; only SRAI may set bit 30
        if ((funct3 == 3'b001 && funct7 == 7'h00) ||
            (funct3 == 3'b101 && (funct7 == 7'h00 || funct7 == 7'h20)) ||
            (funct3 != 3'b001 && funct3 != 3'b101)) begin
          legal         = 1'b1;
          dec_c.reg_we  = 1'b1;
          dec_c.alu_cfg = 1'b1;
          dec_c.alu_op  = {2'b01, (funct3 == 3'b101) & in_instr[30], funct3};
        end
      end
      OPC_LOAD: begin
        if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
          legal            = 1'b1;
          dec_c.reg_we     = 1'b1;
          dec_c.result_src = 2'd1;
          dec_c.alu_cfg    = 1'b1;
          dec_c.alu_op     = ALU_ADD;
        end
      end
      OPC_STORE: begin
        if (funct3 inside {3'b000, 3'b001, 3'b010}) begin
          legal          = 1'b1;
          dec_c.mem_we   = 1'b1;
          dec_c.alu_cfg  = 1'b1;
          dec_c.imm_sel  = IMM_S;
          dec_c.alu_op   = ALU_ADD;
        end
      end
      OPC_BRANCH: begin
        if (funct3 != 3'b010 && funct3 != 3'b011) begin
          legal           = 1'b1;
          dec_c.is_branch = 1'b1;
          dec_c.imm_sel   = IMM_B;
          dec_c.alu_op    = {2'b10, 1'b0, funct3};
        end
      end
      OPC_JAL, OPC_JALR: begin
        if (opcode == OPC_JAL || funct3 == 3'b000) begin
          legal            = 1'b1;
          dec_c.is_jump    = 1'b1;
          dec_c.reg_we     = 1'b1;
          dec_c.result_src = 2'd2;
          dec_c.alu_cfg    = 1'b1;
          dec_c.imm_sel    = (opcode == OPC_JAL) ? IMM_J : IMM_I;
          dec_c.alu_op     = ALU_ADD;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        legal         = 1'b1;
        dec_c.reg_we  = 1'b1;
        dec_c.alu_cfg = 1'b1;
        dec_c.imm_sel = IMM_U;
        dec_c.alu_op  = ALU_ADD;
      end
      OPC_SYSTEM: begin
        if (ENABLE_SYSTEM != 0) begin
          if (in_instr == 32'h0000_0073) begin
            legal       = 1'b1;
            dec_c.ecall = 1'b1;
          end else if (in_instr == 32'h0010_0073) begin
            legal        = 1'b1;
            dec_c.ebreak = 1'b1;
          end
        end
      end
      default: ;
    endcase
    dec_c.illegal = !legal;
    // x0 is never written
    if (dec_c.rd == '0) dec_c.reg_we = 1'b0;

    case (dec_c.imm_sel)
      IMM_U:   imm32 = {in_instr[31:12], 12'b0};
      IMM_J:   imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      IMM_B:   imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      IMM_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      default: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
    endcase
    dec_c.imm = XLEN'($signed(imm32));
  end

  // With the skid enabled, ready only depends on whether the spare slot is free
  assign in_ready_c = (SKID_EN != 0) ? !skid_valid_q : (!out_valid_q || out_ready);
  assign accept_c   = in_valid && in_ready_c && !flush;
  assign fire_c     = out_valid_q && out_ready;

  // Output slot and skid slot next-state
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || fire_c) begin
      if (skid_valid_q) begin
        // Older skid entry goes out first; a same-cycle accept refills the skid
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = accept_c;
        if (accept_c) skid_d = dec_c;
      end else begin
        out_valid_d = accept_c;
        if (accept_c) out_d = dec_c;
      end
    end else if (accept_c) begin
      skid_d       = dec_c;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready             = in_ready_c;
  assign out_valid            = out_valid_q;
  assign out_pc               = out_q.pc;
  assign out_rd               = out_q.rd;
  assign out_rs1              = out_q.rs1;
  assign out_rs2              = out_q.rs2;
  assign out_imm              = out_q.imm;
  assign out_reg_write_enable = out_q.reg_we;
  assign out_result_src       = out_q.result_src;
  assign out_is_branch        = out_q.is_branch;
  assign out_is_jump          = out_q.is_jump;
  assign out_mem_write_enable = out_q.mem_we;
  assign out_mem_funct3       = out_q.mem_funct3;
  assign out_alu_op           = out_q.alu_op;
  assign out_alu_input_config = out_q.alu_cfg;
  assign out_imm_sel          = out_q.imm_sel;
  assign out_illegal          = out_q.illegal;
  assign out_ecall            = out_q.ecall;
  assign out_ebreak           = out_q.ebreak;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a decoder model written from the ISA rules plus a
// queue of in-flight instructions, checked every cycle, together with
// hand-computed literal expectations for selected instructions.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        rw;
    logic [1:0]  rsrc;
    logic        br;
    logic        jmp;
    logic        mw;
    logic [2:0]  mf3;
    logic [5:0]  aop;
    logic        acfg;
    logic [2:0]  isel;
    logic        ill;
    logic        ec;
    logic        eb;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } txn_t;

  typedef enum int {K_ILL, K_R, K_IALU, K_LOAD, K_STORE, K_BR, K_JAL, K_JALR,
                    K_LUI, K_AUIPC, K_ECALL, K_EBREAK} kind_e;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic in_ready, ns_in_ready;

  logic out_valid, out_rw, out_br, out_jmp, out_mw, out_acfg, out_ill, out_ec, out_eb;
  logic [31:0] out_pc, out_imm;
  logic [4:0] out_rd, out_rs1, out_rs2;
  logic [1:0] out_rsrc;
  logic [2:0] out_mf3, out_isel;
  logic [5:0] out_aop;

  logic ns_valid, ns_rw, ns_br, ns_jmp, ns_mw, ns_acfg, ns_ill, ns_ec, ns_eb;
  logic [31:0] ns_pc, ns_imm;
  logic [4:0] ns_rd, ns_rs1, ns_rs2;
  logic [1:0] ns_rsrc;
  logic [2:0] ns_mf3, ns_isel;
  logic [5:0] ns_aop;

  int checks = 0;
  int errors = 0;
  txn_t q[$];
  logic [31:0] delivered[$];
  logic last_acc = 1'b0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .SKID_EN(1), .ENABLE_SYSTEM(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_reg_write_enable(out_rw), .out_result_src(out_rsrc), .out_is_branch(out_br),
    .out_is_jump(out_jmp), .out_mem_write_enable(out_mw), .out_mem_funct3(out_mf3),
    .out_alu_op(out_aop), .out_alu_input_config(out_acfg), .out_imm_sel(out_isel),
    .out_illegal(out_ill), .out_ecall(out_ec), .out_ebreak(out_eb));

  decode_stage #(.XLEN(32), .SKID_EN(1), .ENABLE_SYSTEM(0)) dut_ns (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ns_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(ns_valid), .out_ready(out_ready),
    .out_pc(ns_pc), .out_rd(ns_rd), .out_rs1(ns_rs1), .out_rs2(ns_rs2), .out_imm(ns_imm),
    .out_reg_write_enable(ns_rw), .out_result_src(ns_rsrc), .out_is_branch(ns_br),
    .out_is_jump(ns_jmp), .out_mem_write_enable(ns_mw), .out_mem_funct3(ns_mf3),
    .out_alu_op(ns_aop), .out_alu_input_config(ns_acfg), .out_imm_sel(ns_isel),
    .out_illegal(ns_ill), .out_ecall(ns_ec), .out_ebreak(ns_eb));

  function automatic kind_e classify(input logic [31:0] ins, input bit sys_en);
    int op, f3, f7;
    op = int'(ins[6:0]);
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    case (op)
      'h33: return (f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5))) ? K_R : K_ILL;
      'h13: begin
        if (f3 == 1) return (f7 == 0) ? K_IALU : K_ILL;
        if (f3 == 5) return (f7 == 0 || f7 == 'h20) ? K_IALU : K_ILL;
        return K_IALU;
      end
      'h03: return (f3 == 3 || f3 > 5) ? K_ILL : K_LOAD;
      'h23: return (f3 <= 2) ? K_STORE : K_ILL;
      'h63: return (f3 == 2 || f3 == 3) ? K_ILL : K_BR;
      'h6F: return K_JAL;
      'h67: return (f3 == 0) ? K_JALR : K_ILL;
      'h37: return K_LUI;
      'h17: return K_AUIPC;
      'h73: begin
        if (sys_en && ins == 32'h0000_0073) return K_ECALL;
        if (sys_en && ins == 32'h0010_0073) return K_EBREAK;
        return K_ILL;
      end
      default: return K_ILL;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input bit sys_en);
    exp_t e;
    kind_e k;
    logic [31:0] sx;
    int f3;
    k  = classify(ins, sys_en);
    sx = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    f3 = int'(ins[14:12]);
    e = '0;
    e.pc  = pc;
    e.rd  = ins[11:7];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.mf3 = ins[14:12];
    e.ill = (k == K_ILL);
    e.ec  = (k == K_ECALL);
    e.eb  = (k == K_EBREAK);
    e.br  = (k == K_BR);
    e.jmp = (k == K_JAL || k == K_JALR);
    e.mw  = (k == K_STORE);
    e.rw  = (k inside {K_R, K_IALU, K_LOAD, K_JAL, K_JALR, K_LUI, K_AUIPC}) && (ins[11:7] != 5'd0);
    e.rsrc = (k == K_LOAD) ? 2'd1 : (e.jmp ? 2'd2 : 2'd0);
    e.acfg = k inside {K_IALU, K_LOAD, K_STORE, K_JAL, K_JALR, K_LUI, K_AUIPC};
    case (k)
      K_R:     e.aop = 6'(f3 + (ins[30] ? 8 : 0));
      K_IALU:  e.aop = 6'(16 + f3 + ((f3 == 5 && ins[30]) ? 8 : 0));
      K_BR:    e.aop = 6'(32 + f3);
      K_LOAD, K_STORE, K_JAL, K_JALR, K_LUI, K_AUIPC: e.aop = 6'd48;
      default: e.aop = 6'd0;
    endcase
    case (k)
      K_LUI, K_AUIPC: e.isel = 3'd1;
      K_JAL:          e.isel = 3'd2;
      K_BR:           e.isel = 3'd3;
      K_STORE:        e.isel = 3'd4;
      default:        e.isel = 3'd0;
    endcase
    case (e.isel)
      3'd1: e.imm = ins & 32'hFFFF_F000;
      3'd2: e.imm = (sx << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      3'd3: e.imm = (sx << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      3'd4: e.imm = (sx << 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
      default: e.imm = (sx << 12) | 32'(ins[31:20]);
    endcase
    return e;
  endfunction

  function automatic exp_t dut_bundle();
    exp_t a;
    a.pc = out_pc; a.rd = out_rd; a.rs1 = out_rs1; a.rs2 = out_rs2; a.imm = out_imm;
    a.rw = out_rw; a.rsrc = out_rsrc; a.br = out_br; a.jmp = out_jmp; a.mw = out_mw;
    a.mf3 = out_mf3; a.aop = out_aop; a.acfg = out_acfg; a.isel = out_isel;
    a.ill = out_ill; a.ec = out_ec; a.eb = out_eb;
    return a;
  endfunction

  function automatic exp_t ns_bundle();
    exp_t a;
    a.pc = ns_pc; a.rd = ns_rd; a.rs1 = ns_rs1; a.rs2 = ns_rs2; a.imm = ns_imm;
    a.rw = ns_rw; a.rsrc = ns_rsrc; a.br = ns_br; a.jmp = ns_jmp; a.mw = ns_mw;
    a.mf3 = ns_mf3; a.aop = ns_aop; a.acfg = ns_acfg; a.isel = ns_isel;
    a.ill = ns_ill; a.ec = ns_ec; a.eb = ns_eb;
    return a;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_b(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle scoreboard, run mid-cycle while inputs and outputs are stable
  task automatic sb_tick();
    logic acc, fire;
    if (rst) begin
      q.delete();
      last_acc = 1'b0;
      return;
    end
    check1("sb_out_valid", out_valid, q.size() > 0);
    check1("sb_ns_out_valid", ns_valid, q.size() > 0);
    check1("sb_in_ready", in_ready, q.size() < 2);
    check1("sb_ns_in_ready", ns_in_ready, q.size() < 2);
    if (q.size() > 0 && out_valid) begin
      check_b("sb_bundle", dut_bundle(), model(q[0].instr, q[0].pc, 1'b1));
      check_b("sb_ns_bundle", ns_bundle(), model(q[0].instr, q[0].pc, 1'b0));
    end
    acc  = in_valid && in_ready && !flush;
    fire = out_valid && out_ready;
    if (flush) begin
      q.delete();
    end else begin
      if (fire && q.size() > 0) begin
        delivered.push_back(q[0].pc);
        void'(q.pop_front());
      end
      if (acc) q.push_back('{instr: in_instr, pc: in_pc});
    end
    last_acc = acc;
  endtask

  task automatic cycle();
    @(negedge clk);
    sb_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (last_acc) break;
    end
    check1("send_accepted", last_acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0) break;
      cycle();
    end
    check32("drain_empty", 32'(q.size()), 32'd0);
  endtask

  logic [31:0] ill_vec [10];
  logic        ill_exp [10];

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0;

    // Reset held for two cycles
    cycle(); cycle();
    check1("rst_out_valid", out_valid, 1'b0);
    check_b("rst_bundle_zero", dut_bundle(), exp_t'(0));
    check_b("rst_ns_bundle_zero", ns_bundle(), exp_t'(0));
    rst = 1'b0;
    cycle();
    check1("rst_in_ready", in_ready, 1'b1);

    // ADDI x1, x0, -1
    out_ready = 1'b1;
    send(32'hFFF0_0093, 32'h100);
    check1("addi_valid", out_valid, 1'b1);
    check32("addi_rd", 32'(out_rd), 32'd1);
    check32("addi_imm", out_imm, 32'hFFFF_FFFF);
    check1("addi_rw", out_rw, 1'b1);
    check1("addi_acfg", out_acfg, 1'b1);
    check32("addi_rsrc", 32'(out_rsrc), 32'd0);
    check32("addi_pc", out_pc, 32'h100);

    // JAL x1, +8 and SW x1, 4(x2)
    send(32'h0080_00EF, 32'h104);
    check32("jal_imm", out_imm, 32'd8);
    check1("jal_jump", out_jmp, 1'b1);
    check32("jal_rsrc", 32'(out_rsrc), 32'd2);
    check32("jal_isel", 32'(out_isel), 32'd2);
    send(32'h0011_2223, 32'h108);
    check1("sw_mw", out_mw, 1'b1);
    check32("sw_imm", out_imm, 32'd4);
    check32("sw_isel", 32'(out_isel), 32'd4);
    check1("sw_rw", out_rw, 1'b0);

    // Illegal and system words
    send(32'h0000_0000, 32'h10C);
    check1("zero_ill", out_ill, 1'b1);
    check32("zero_enables", {27'd0, out_rw, out_mw, out_br, out_jmp, out_ec | out_eb}, 32'd0);
    send(32'h0000_0073, 32'h110);
    check1("ecall", out_ec, 1'b1);
    check1("ecall_legal", out_ill, 1'b0);
    check1("ns_ecall_ill", ns_ill, 1'b1);
    check1("ns_ecall_off", ns_ec, 1'b0);
    send(32'h0010_0073, 32'h114);
    check1("ebreak", out_eb, 1'b1);
    check1("ns_ebreak_ill", ns_ill, 1'b1);

    ill_vec = '{32'h4010_5093, 32'h4010_1093, 32'h4000_1033, 32'h4000_0033, 32'h0000_2063,
                32'h0000_3003, 32'h3000_2073, 32'h0000_000F, 32'h0000_0003, 32'h0000_1067};
    ill_exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      send(ill_vec[i], 32'h200 + 32'(i) * 4);
      check1($sformatf("illegal_vec%0d", i), out_ill, ill_exp[i]);
    end
    drain();

    // Back-pressure: A, B fill output and skid, C must wait
    delivered.delete();
    out_ready = 1'b0;
    send(32'h0010_0113, 32'h300);
    send(32'h0020_0193, 32'h304);
    check1("skid_full_in_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_instr = 32'h0030_0213; in_pc = 32'h308;
    cycle();
    check1("c_blocked", last_acc, 1'b0);
    out_ready = 1'b1;
    send(32'h0030_0213, 32'h308);
    drain();
    check32("order_count", 32'(delivered.size()), 32'd3);
    if (delivered.size() == 3) begin
      check32("order_a", delivered[0], 32'h300);
      check32("order_b", delivered[1], 32'h304);
      check32("order_c", delivered[2], 32'h308);
    end

    // Flush with output and skid both occupied
    out_ready = 1'b0;
    send(32'h0010_0113, 32'h400);
    send(32'h0020_0193, 32'h404);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0030_0213; in_pc = 32'h408;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    check1("flush_out_valid", out_valid, 1'b0);
    check1("flush_in_ready", in_ready, 1'b1);

    // Flush while the stage could accept: the incoming word is dropped
    send(32'h0010_0113, 32'h500);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0050_0293; in_pc = 32'h504;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    cycle();
    check1("flush_drop_valid", out_valid, 1'b0);

    out_ready = 1'b1;
    send(32'hFFF0_0093, 32'h600);
    check32("post_flush_pc", out_pc, 32'h600);
    check32("post_flush_imm", out_imm, 32'hFFFF_FFFF);
    check32("post_flush_rd", 32'(out_rd), 32'd1);
    drain();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
